// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory path: funct3 codes, LSU state encoding
// and small decode helpers.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // RDWAIT covers the synchronous RAM latency of the last word read.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC0   = 3'd1,
    ACC1   = 3'd2,
    RESP   = 3'd3,
    RDWAIT = 3'd4
  } lsu_state_t;

  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store mask/data shift into a 64-bit two-word window and
// load shift plus sign/zero extension out of it.
module riscv_lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [63:0] i_rword,
  output logic [7:0]  o_mask,
  output logic [63:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [5:0]  w_shamt;
  logic [7:0]  w_size_mask;
  logic [63:0] w_shifted;

  always_comb begin
    w_shamt = {1'b0, i_off, 3'b000};
    case (i_funct3[1:0])
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      default: w_size_mask = 8'h0F;
    endcase
    o_mask    = w_size_mask << i_off;
    o_wdata   = {32'h0, i_wdata} << w_shamt;
    w_shifted = i_rword >> w_shamt;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_rdata = {24'h0, w_shifted[7:0]};
      F3_HU:   o_rdata = {16'h0, w_shifted[15:0]};
      default: o_rdata = w_shifted[31:0];
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time, misaligned accesses split into two
// word accesses, registered response for write-back.
module riscv_lsu
  import riscv_mem_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int MEM_AW           = 30
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        r_state, w_state_next;
  logic              r_we, r_split;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [3:0]        r_mask_hi;
  logic [31:0]       r_wdata_hi, r_lo;
  logic [MEM_AW-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic              r_rsp_valid, r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic              w_idle, w_split, w_err;
  logic [2:0]        w_size, w_f3;
  logic [1:0]        w_off;
  logic [3:0]        w_end;
  logic [7:0]        w_mask;
  logic [63:0]       w_wdata64, w_rword;
  logic [31:0]       w_load;

  // While idle the aligner decodes the incoming request; afterwards the latched one.
  assign w_idle  = (r_state == IDLE);
  assign w_f3    = w_idle ? req_funct3 : r_f3;
  assign w_off   = w_idle ? req_addr[1:0] : r_off;
  assign w_size  = f3_size(req_funct3);
  assign w_end   = {2'b00, req_addr[1:0]} + {1'b0, w_size};
  assign w_split = (w_end > 4'd4);
  assign w_err   = !f3_legal(req_we, req_funct3) || (w_split && !ALLOW_MISALIGNED);
  assign w_rword = r_split ? {mem_rdata, r_lo} : {32'h0, mem_rdata};

  riscv_lsu_align u_align (
    .i_funct3 (w_f3),
    .i_off    (w_off),
    .i_wdata  (req_wdata),
    .i_rword  (w_rword),
    .o_mask   (w_mask),
    .o_wdata  (w_wdata64),
    .o_rdata  (w_load)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_next = w_err ? RESP : ACC0;
      ACC0:    w_state_next = r_split ? ACC1 : RDWAIT;
      ACC1:    w_state_next = RDWAIT;
      RDWAIT:  w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_split     <= 1'b0;
      r_f3        <= 3'b000;
      r_off       <= 2'b00;
      r_mask_hi   <= 4'h0;
      r_wdata_hi  <= 32'h0;
      r_lo        <= 32'h0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= (w_state_next == RESP);
      if (w_idle && req_valid) begin
        r_we       <= req_we;
        r_f3       <= req_funct3;
        r_off      <= req_addr[1:0];
        r_split    <= w_split;
        r_mask_hi  <= w_mask[7:4];
        r_wdata_hi <= w_wdata64[63:32];
      end
      case (r_state)
        IDLE: if (req_valid && !w_err) begin
          r_mem_addr  <= MEM_AW'(req_addr[31:2]);
          r_mem_we    <= req_we;
          r_mem_be    <= w_mask[3:0];
          r_mem_wdata <= w_wdata64[31:0];
        end
        ACC0: if (r_split) begin
          r_mem_addr  <= r_mem_addr + MEM_AW'(1);
          r_mem_be    <= r_mask_hi;
          r_mem_wdata <= r_wdata_hi;
        end else begin
          r_mem_we <= 1'b0;
          r_mem_be <= 4'h0;
        end
        ACC1: begin
          r_lo     <= mem_rdata;
          r_mem_we <= 1'b0;
          r_mem_be <= 4'h0;
        end
        default: ;
      endcase
      // Only IDLE (error path) and RDWAIT can lead into RESP.
      if (w_state_next == RESP) begin
        r_rsp_err   <= w_idle;
        r_rsp_rdata <= (w_idle || r_we) ? 32'h0 : w_load;
      end else begin
        r_rsp_err <= 1'b0;
      end
    end
  end

  assign req_ready = w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a misalignment-splitting instance with a synchronous RAM
// model and a strict instance for the no-split error path.
module tb_riscv_lsu;
  import riscv_mem_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  logic        req_valid = 1'b0, sel = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

  logic        a_valid, a_ready, a_rsp_valid, a_rsp_err, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_wdata, a_mem_rdata;
  logic [29:0] a_mem_addr;
  logic [3:0]  a_mem_be;
  logic        b_valid, b_ready, b_rsp_valid, b_rsp_err, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_wdata, b_mem_rdata;
  logic [29:0] b_mem_addr;
  logic [3:0]  b_mem_be;

  assign a_valid     = req_valid & ~sel;
  assign b_valid     = req_valid & sel;
  assign b_mem_rdata = 32'h0;

  riscv_lsu #(.ALLOW_MISALIGNED(1'b1), .MEM_AW(30)) u_dut (
    .Clock(Clock), .Reset(Reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_be(a_mem_be),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

  riscv_lsu #(.ALLOW_MISALIGNED(1'b0), .MEM_AW(30)) u_dut_na (
    .Clock(Clock), .Reset(Reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  // Synchronous RAM model for the main instance, with a backdoor preload port.
  logic [31:0] ram [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = 8'h0;
  logic [31:0] bd_data = 32'h0;
  always @(posedge Clock) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (a_mem_we)
      for (int i = 0; i < 4; i++)
        if (a_mem_be[i]) ram[a_mem_addr[7:0]][8*i +: 8] <= a_mem_wdata[8*i +: 8];
    a_mem_rdata <= ram[a_mem_addr[7:0]];
  end

  logic        c_ready, c_rsp_valid, c_rsp_err, c_mem_we;
  logic [31:0] c_rsp_rdata;
  logic [29:0] c_mem_addr;
  logic [3:0]  c_mem_be;
  logic [31:0] c_mem_wdata;
  assign c_ready     = sel ? b_ready     : a_ready;
  assign c_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign c_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign c_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign c_mem_we    = sel ? b_mem_we    : a_mem_we;
  assign c_mem_be    = sel ? b_mem_be    : a_mem_be;
  assign c_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign c_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [29:0] cap_addr [1:8];
  logic [3:0]  cap_be   [1:8];
  logic        cap_we   [1:8];
  logic [31:0] cap_wd   [1:8];
  int          rsp_k;
  logic [31:0] rsp_data;
  logic        rsp_e, rsp_rdy;

  localparam logic [2:0]  AL_F3 [5] = '{F3_W, F3_B, F3_BU, F3_H, F3_HU};
  localparam logic [31:0] AL_AD [5] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h100};
  localparam logic [31:0] AL_EX [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE,
                                        32'hFFFFDEAD, 32'h0000BEEF};
  localparam logic        BB_WE [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [2:0]  BB_F3 [5] = '{F3_W, F3_B, F3_W, F3_HU, F3_B};
  localparam logic [31:0] BB_AD [5] = '{32'h300, 32'h301, 32'h300, 32'h302, 32'h301};
  localparam logic [31:0] BB_WD [5] = '{32'hCAFEF00D, 32'hFFFFFF5A, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] BB_EX [5] = '{32'h0, 32'h0, 32'hCAFE5A0D, 32'h0000CAFE, 32'h0000005A};
  localparam logic        ER_SEL [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic        ER_WE  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [2:0]  ER_F3  [5] = '{3'b011, F3_BU, F3_W, F3_H, F3_W};
  localparam logic [31:0] ER_AD  [5] = '{32'h100, 32'h100, 32'h101, 32'h203, 32'h100};
  localparam logic        ER_ERR [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam int          ER_LAT [5] = '{1, 1, 1, 1, 3};

  task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge Clock);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge Clock);
    #1 bd_we = 1'b0;
  endtask

  // Records mem_* per cycle after accept (index 1 = T+1) until the response appears.
  task automatic capture(input int budget);
    rsp_k = 0;
    for (int k = 1; k <= budget && rsp_k == 0; k++) begin
      @(negedge Clock);
      cap_addr[k] = c_mem_addr; cap_be[k] = c_mem_be;
      cap_we[k]   = c_mem_we;   cap_wd[k] = c_mem_wdata;
      if (c_rsp_valid) begin
        rsp_k = k; rsp_data = c_rsp_rdata; rsp_e = c_rsp_err; rsp_rdy = c_ready;
      end
    end
  endtask

  task automatic run_txn(input logic s, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
    sb.push_back(e);
    @(negedge Clock);
    sel = s; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge Clock);
    #1 req_valid = 1'b0;
    capture(8);
    $display("txn dut=%0d we=%0b f3=%03b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             s, we, f3, addr, wd, rsp_data, rsp_e, rsp_k);
  endtask

  task automatic test_reset();
    @(negedge Clock);
    n_cmp++;
    if ({a_rsp_valid, a_rsp_err, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata, a_rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b err=%b we=%b be=%b addr=%h wd=%h rd=%h, want all 0",
               a_rsp_valid, a_rsp_err, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata, a_rsp_rdata);
    end
    Reset = 1'b0;
    @(negedge Clock);
    n_cmp++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b/%b want 1/1", a_ready, b_ready);
    end
  endtask

  task automatic test_aligned_load();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, 1'b0, AL_F3[i], AL_AD[i], 32'h0, AL_EX[i], 1'b0, 3);
      e = sb.pop_front();
      n_cmp++;
      if (rsp_k != e.lat) begin
        n_bad++; $display("FAIL aligned_lat[%0d]: got %0d want %0d", i, rsp_k, e.lat);
      end
      n_cmp++;
      if (rsp_data !== e.rdata || rsp_e !== e.err) begin
        n_bad++; $display("FAIL aligned_rsp[%0d]: got %h/%b want %h/%b", i, rsp_data, rsp_e, e.rdata, e.err);
      end
      n_cmp++;
      if (cap_addr[1] !== 30'h40 || cap_we[1] !== 1'b0) begin
        n_bad++; $display("FAIL aligned_mem[%0d]: got addr=%h we=%b want 40/0", i, cap_addr[1], cap_we[1]);
      end
    end
  endtask

  task automatic test_split_load();
    exp_t e;
    run_txn(1'b0, 1'b0, F3_W, 32'h1FE, 32'h0, 32'h3344AABB, 1'b0, 4);
    e = sb.pop_front();
    n_cmp++;
    if (rsp_k != e.lat || rsp_data !== e.rdata || rsp_e !== e.err) begin
      n_bad++; $display("FAIL split_lw_rsp: got lat=%0d %h/%b want lat=%0d %h/%b",
                        rsp_k, rsp_data, rsp_e, e.lat, e.rdata, e.err);
    end
    n_cmp++;
    if (cap_addr[1] !== 30'h7F || cap_be[1] !== 4'b1100 || cap_addr[2] !== 30'h80 || cap_be[2] !== 4'b0011) begin
      n_bad++; $display("FAIL split_lw_mem: got %h/%b %h/%b want 7f/1100 80/0011",
                        cap_addr[1], cap_be[1], cap_addr[2], cap_be[2]);
    end
  endtask

  task automatic test_split_store();
    exp_t e;
    run_txn(1'b0, 1'b1, F3_H, 32'h203, 32'h00001234, 32'h0, 1'b0, 4);
    e = sb.pop_front();
    n_cmp++;
    if (rsp_k != e.lat || rsp_data !== e.rdata || rsp_e !== e.err) begin
      n_bad++; $display("FAIL split_sh_rsp: got lat=%0d %h/%b want lat=%0d %h/%b",
                        rsp_k, rsp_data, rsp_e, e.lat, e.rdata, e.err);
    end
    n_cmp++;
    if (cap_addr[1] !== 30'h80 || cap_be[1] !== 4'b1000 || cap_wd[1][31:24] !== 8'h34 || cap_we[1] !== 1'b1) begin
      n_bad++; $display("FAIL split_sh_acc0: got addr=%h be=%b wd=%h we=%b want 80/1000/34xxxxxx/1",
                        cap_addr[1], cap_be[1], cap_wd[1], cap_we[1]);
    end
    n_cmp++;
    if (cap_addr[2] !== 30'h81 || cap_be[2] !== 4'b0001 || cap_wd[2][7:0] !== 8'h12 || cap_we[2] !== 1'b1) begin
      n_bad++; $display("FAIL split_sh_acc1: got addr=%h be=%b wd=%h we=%b want 81/0001/xxxxxx12/1",
                        cap_addr[2], cap_be[2], cap_wd[2], cap_we[2]);
    end
    n_cmp++;
    if (ram[8'h80] !== 32'h34223344 || ram[8'h81] !== 32'h00000012) begin
      n_bad++; $display("FAIL split_sh_ram: got %h %h want 34223344 00000012", ram[8'h80], ram[8'h81]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, BB_WE[i], BB_F3[i], BB_AD[i], BB_WD[i], BB_EX[i], 1'b0, 3);
      e = sb.pop_front();
      n_cmp++;
      if (rsp_k != e.lat || rsp_data !== e.rdata || rsp_e !== e.err) begin
        n_bad++; $display("FAIL b2b_rsp[%0d]: got lat=%0d %h/%b want lat=%0d %h/%b",
                          i, rsp_k, rsp_data, rsp_e, e.lat, e.rdata, e.err);
      end
      n_cmp++;
      if (rsp_rdy !== 1'b0) begin
        n_bad++; $display("FAIL b2b_ready_in_resp[%0d]: got %b want 0", i, rsp_rdy);
      end
    end
  endtask

  task automatic test_errors();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      run_txn(ER_SEL[i], ER_WE[i], ER_F3[i], ER_AD[i], 32'hFFFFFFFF, 32'h0, ER_ERR[i], ER_LAT[i]);
      e = sb.pop_front();
      n_cmp++;
      if (rsp_k != e.lat || rsp_data !== e.rdata || rsp_e !== e.err) begin
        n_bad++; $display("FAIL err_rsp[%0d]: got lat=%0d %h/%b want lat=%0d %h/%b",
                          i, rsp_k, rsp_data, rsp_e, e.lat, e.rdata, e.err);
      end
      if (ER_ERR[i]) begin
        @(negedge Clock);
        n_cmp++;
        if (cap_we[1] !== 1'b0 || cap_be[1] !== 4'h0 || c_mem_we !== 1'b0 || c_mem_be !== 4'h0) begin
          n_bad++; $display("FAIL err_no_mem[%0d]: got we=%b be=%b then we=%b be=%b want 0",
                            i, cap_we[1], cap_be[1], c_mem_we, c_mem_be);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge Clock);
    sel = 1'b0; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h2C3; req_wdata = 32'h0000ABCD;
    req_valid = 1'b1;
    @(posedge Clock);
    #1 req_valid = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    n_cmp++;
    if (a_mem_be !== 4'b0001 || a_mem_we !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_acc1: got be=%b we=%b want 0001/1", a_mem_be, a_mem_we);
    end
    #1 Reset = 1'b1;
    #1;
    n_cmp++;
    if (a_mem_we !== 1'b0 || a_mem_be !== 4'h0 || a_rsp_valid !== 1'b0 || a_mem_addr !== 30'h0) begin
      n_bad++; $display("FAIL rstmid_outputs: got we=%b be=%b valid=%b addr=%h want 0",
                        a_mem_we, a_mem_be, a_rsp_valid, a_mem_addr);
    end
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    n_cmp++;
    if (a_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_ready: got ready=%b valid=%b want 1/0", a_ready, a_rsp_valid);
    end
    run_txn(1'b0, 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    e = sb.pop_front();
    n_cmp++;
    if (rsp_k != e.lat || rsp_data !== e.rdata || rsp_e !== e.err) begin
      n_bad++; $display("FAIL rstmid_recover: got lat=%0d %h/%b want lat=%0d %h/%b",
                        rsp_k, rsp_data, rsp_e, e.lat, e.rdata, e.err);
    end
  endtask

  initial begin
    bd_write(8'h40, 32'hDEADBEEF);
    bd_write(8'h7F, 32'hAABBCCDD);
    bd_write(8'h80, 32'h11223344);
    bd_write(8'h81, 32'h00000000);
    bd_write(8'hB0, 32'h00000000);
    bd_write(8'hB1, 32'h00000000);
    bd_write(8'hC0, 32'h00000000);
    test_reset();
    test_aligned_load();
    test_split_load();
    test_split_store();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
